hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It is the producer side of the forwarding path.
- Carries a shadow copy of the ID/EX, EX/MEM and MEM/WB destination/control fields.
- Drives EX_MEM_RegWrite/rd, MEM_WB_RegWrite/rd and ID_EX_rs1/rs2 straight into the forwarding unit.
- Generates load-use stalls, branch flushes and data-memory wait freezes.

Parameters:
MEM_TIMEOUT, 64, max consecutive freeze cycles before mem_timeout asserts (>=2)
CNT_W, 16, width of stall_count performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  5  ID source 1
id_rs2  in  5  ID source 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  5  ID destination
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
id_memwrite  in  1  ID instruction is a store
branch_taken_ex  in  1  EX resolved a taken branch/jump this cycle
mem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  zero IF/ID register
id_ex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
ID_EX_rs1  out  5  to forwarding unit
ID_EX_rs2  out  5  to forwarding unit
EX_MEM_RegWrite  out  1  to forwarding unit
EX_MEM_rd  out  5  to forwarding unit
MEM_WB_RegWrite  out  1  to forwarding unit
MEM_WB_rd  out  5  to forwarding unit
mem_timeout  out  1  sticky error
stall_count  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
Shadow registers:
- ID/EX: {valid, rs1, rs2, rd, regwrite, memread, memwrite}
- EX/MEM: {regwrite, rd, memaccess}
- MEM/WB: {regwrite, rd}
- All fields are 0 on rst; every output is 0 on reset.
- Each unfrozen cycle every stage advances by one. Latency ID->EX_MEM_rd is 2 cycles; ID->MEM_WB_rd is 3 cycles.
- A NOP has all fields 0, including rd=0 and regwrite=0.

Load-use (combinational):
- luse = id_valid & ID/EX.memread & ID/EX.regwrite & ID/EX.rd!=0 & ((id_rs1_used & id_rs1==ID/EX.rd) | (id_rs2_used & id_rs2==ID/EX.rd)).
- On luse: pc_stall=1, if_id_stall=1, id_ex_bubble=1, and ID/EX loads a NOP. Exactly one bubble is inserted per load-use pair.

Branch:
- branch_taken_ex=1 drives if_id_flush=1 and id_ex_bubble=1; ID/EX loads a NOP.
- Branch overrides luse: pc_stall and if_id_stall stay 0 so the PC takes the target.

Freeze FSM, states RUN, WAIT, ERR:
- RUN -> WAIT when EX/MEM.memaccess & !mem_ready. pipe_freeze, pc_stall and if_id_stall assert combinationally in that same cycle.
- WAIT: freeze held while !mem_ready; the wait counter increments each cycle.
- WAIT -> RUN on mem_ready. The freeze drops in that cycle and the pipeline advances.
- WAIT -> ERR when the counter reaches MEM_TIMEOUT-1 without mem_ready. In ERR, mem_timeout=1 and the freeze is held permanently until rst.
- The wait counter clears on entering RUN.
- During a freeze, all shadow stages hold their value, and branch_taken_ex and luse are ignored (flush and bubble outputs are 0). EX is held, so the branch re-presents after the freeze.

Priority: freeze > branch > load-use.

stall_count:
- Increments on every cycle with pc_stall=1 and saturates at all-ones.
- Counts all three causes.

Reset:
- rst mid-WAIT or in ERR returns to RUN.
- All shadow registers, counters and mem_timeout clear asynchronously.

Decomposition:
- Package hazard_pkg holds:
  - the freeze state enum (RUN/WAIT/ERR)
  - a stage_ctrl struct {regwrite, rd, memread, memwrite}
  - the NOP constant
  - the x0 index constant
- One natural sub-module: mem_wait_fsm. It owns the RUN/WAIT/ERR state, the wait counter and mem_timeout, and outputs pipe_freeze.

Test Plan:
1. Load-use: cycle0 ID = lw x5; cycle1 ID = add x6,x5,x7 (rs1_used=1) -> cycle1 pc_stall=if_id_stall=id_ex_bubble=1 for exactly 1 cycle; cycle2 EX_MEM_rd=5, EX_MEM_RegWrite=1; cycle3 MEM_WB_rd=5; stall_count=1.
2. No false stall: lw x0 followed by add using x0, and lw x5 followed by an instruction with rs2=5 but rs2_used=0 -> no stall.
3. Branch plus load-use in the same cycle: branch_taken_ex=1 with luse true -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; the following cycle ID_EX regwrite=0.
4. Memory wait: store in EX/MEM with mem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles with EX_MEM_rd/MEM_WB_rd unchanged; 4th cycle mem_ready=1 -> advance; stall_count=3.
5. Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4 freeze cycles and stays 1; mem_ready=1 afterwards -> still frozen; rst -> all outputs 0, state RUN.
6. Async reset mid-pipeline: assert rst between clock edges with valid instructions in all stages -> outputs go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] X0 = '0;

   typedef enum logic [1:0] {
      FS_RUN  = 2'd0,
      FS_WAIT = 2'd1,
      FS_ERR  = 2'd2
   } freeze_state_e;

   typedef struct packed {
      logic             regwrite;
      logic [REG_W-1:0] rd;
      logic             memread;
      logic             memwrite;
   } stage_ctrl_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      stage_ctrl_t      ctrl;
   } id_ex_t;

   typedef struct packed {
      logic             regwrite;
      logic [REG_W-1:0] rd;
      logic             memaccess;
   } ex_mem_t;

   typedef struct packed {
      logic             regwrite;
      logic [REG_W-1:0] rd;
   } mem_wb_t;

   localparam stage_ctrl_t CTRL_NOP  = '0;
   localparam id_ex_t      ID_EX_NOP = '{valid: 1'b0, rs1: X0, rs2: X0, ctrl: CTRL_NOP};

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe while an access is pending and
// latches a sticky timeout once the wait runs too long.
module mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
)(
   input  logic clk,
   input  logic rst,
   input  logic i_mem_access,
   input  logic i_mem_ready,
   output logic o_freeze,
   output logic o_timeout
);

   localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   freeze_state_e     r_state;
   freeze_state_e     w_state_nxt;
   logic [WCNT_W-1:0] r_wcnt;
   logic [WCNT_W-1:0] w_wcnt_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FS_RUN;
         r_wcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_wcnt    <= w_wcnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // r_wcnt holds the number of freeze cycles already spent on this access
   always_comb begin
      w_state_nxt   = r_state;
      w_wcnt_nxt    = r_wcnt;
      w_timeout_nxt = r_timeout;
      o_freeze      = 1'b0;
      case (r_state)
         FS_RUN: begin
            w_wcnt_nxt = '0;
            if (i_mem_access && !i_mem_ready) begin
               o_freeze    = 1'b1;
               w_state_nxt = FS_WAIT;
               w_wcnt_nxt  = WCNT_W'(1);
            end
         end
         FS_WAIT: begin
            if (i_mem_ready) begin
               w_state_nxt = FS_RUN;
               w_wcnt_nxt  = '0;
            end else begin
               o_freeze = 1'b1;
               if (r_wcnt >= WCNT_LAST) begin
                  w_state_nxt   = FS_ERR;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_wcnt_nxt = r_wcnt + WCNT_W'(1);
               end
            end
         end
         FS_ERR: begin
            o_freeze = 1'b1;
         end
         default: begin
            w_state_nxt = FS_RUN;
         end
      endcase
   end

   assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow ID/EX, EX/MEM, MEM/WB control fields,
// load-use stalls, branch flushes and memory-wait freezes.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_memwrite,
   input  logic             branch_taken_ex,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_freeze,
   output logic [REG_W-1:0] ID_EX_rs1,
   output logic [REG_W-1:0] ID_EX_rs2,
   output logic             EX_MEM_RegWrite,
   output logic [REG_W-1:0] EX_MEM_rd,
   output logic             MEM_WB_RegWrite,
   output logic [REG_W-1:0] MEM_WB_rd,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   id_ex_t           r_id_ex;
   ex_mem_t          r_ex_mem;
   mem_wb_t          r_mem_wb;
   logic [CNT_W-1:0] r_stall_cnt;

   id_ex_t w_id_in;
   logic   w_freeze;
   logic   w_rs1_hit;
   logic   w_rs2_hit;
   logic   w_luse_raw;
   logic   w_luse;
   logic   w_branch;
   logic   w_bubble;
   logic   w_pc_stall;

   mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_fsm (
      .clk          (clk),
      .rst          (rst),
      .i_mem_access (r_ex_mem.memaccess),
      .i_mem_ready  (mem_ready),
      .o_freeze     (w_freeze),
      .o_timeout    (mem_timeout)
   );

   assign w_rs1_hit  = id_rs1_used && (id_rs1 == r_id_ex.ctrl.rd);
   assign w_rs2_hit  = id_rs2_used && (id_rs2 == r_id_ex.ctrl.rd);
   assign w_luse_raw = id_valid && r_id_ex.valid && r_id_ex.ctrl.memread &&
                       r_id_ex.ctrl.regwrite && (r_id_ex.ctrl.rd != X0) &&
                       (w_rs1_hit || w_rs2_hit);

   // Priority freeze > branch > load-use; reset masks the raw branch input
   assign w_branch   = branch_taken_ex && !rst && !w_freeze;
   assign w_luse     = w_luse_raw && !w_freeze && !branch_taken_ex;
   assign w_bubble   = w_branch || w_luse;
   assign w_pc_stall = w_freeze || w_luse;

   always_comb begin
      w_id_in = ID_EX_NOP;
      if (id_valid) begin
         w_id_in.valid         = 1'b1;
         w_id_in.rs1           = id_rs1;
         w_id_in.rs2           = id_rs2;
         w_id_in.ctrl.regwrite = id_regwrite;
         w_id_in.ctrl.rd       = id_rd;
         w_id_in.ctrl.memread  = id_memread;
         w_id_in.ctrl.memwrite = id_memwrite;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_ex  <= ID_EX_NOP;
         r_ex_mem <= '0;
         r_mem_wb <= '0;
      end else if (!w_freeze) begin
         r_id_ex            <= w_bubble ? ID_EX_NOP : w_id_in;
         r_ex_mem.regwrite  <= r_id_ex.ctrl.regwrite;
         r_ex_mem.rd        <= r_id_ex.ctrl.rd;
         r_ex_mem.memaccess <= r_id_ex.ctrl.memread || r_id_ex.ctrl.memwrite;
         r_mem_wb.regwrite  <= r_ex_mem.regwrite;
         r_mem_wb.rd        <= r_ex_mem.rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_pc_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign pc_stall        = w_pc_stall;
   assign if_id_stall     = w_pc_stall;
   assign if_id_flush     = w_branch;
   assign id_ex_bubble    = w_bubble;
   assign pipe_freeze     = w_freeze;
   assign ID_EX_rs1       = r_id_ex.rs1;
   assign ID_EX_rs2       = r_id_ex.rs2;
   assign EX_MEM_RegWrite = r_ex_mem.regwrite;
   assign EX_MEM_rd       = r_ex_mem.rd;
   assign MEM_WB_RegWrite = r_mem_wb.regwrite;
   assign MEM_WB_rd       = r_mem_wb.rd;
   assign stall_count     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, memory wait, timeout, reset.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_used, id_rs2_used;
   logic        id_regwrite, id_memread, id_memwrite;
   logic        branch_taken_ex, mem_ready;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze;
   logic [4:0]  ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, MEM_WB_rd;
   logic        EX_MEM_RegWrite, MEM_WB_RegWrite, mem_timeout;
   logic [15:0] stall_count;
   logic [43:0] all_out;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_used     (id_rs2_used),
      .id_rd           (id_rd),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .id_memwrite     (id_memwrite),
      .branch_taken_ex (branch_taken_ex),
      .mem_ready       (mem_ready),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .pipe_freeze     (pipe_freeze),
      .ID_EX_rs1       (ID_EX_rs1),
      .ID_EX_rs2       (ID_EX_rs2),
      .EX_MEM_RegWrite (EX_MEM_RegWrite),
      .EX_MEM_rd       (EX_MEM_rd),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .MEM_WB_rd       (MEM_WB_rd),
      .mem_timeout     (mem_timeout),
      .stall_count     (stall_count)
   );

   assign all_out = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze,
                     ID_EX_rs1, ID_EX_rs2, EX_MEM_RegWrite, EX_MEM_rd,
                     MEM_WB_RegWrite, MEM_WB_rd, mem_timeout, stall_count};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
      id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
   endtask

   task automatic set_nop();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_nop();
      branch_taken_ex = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_nop();
      mem_ready = 1'b1;
      branch_taken_ex = 1'b1;
      #2;
      checks++;
      if (all_out !== 44'd0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      branch_taken_ex = 1'b0;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (all_out !== 44'd0) begin
         errors++; $display("FAIL post_reset_outputs: got %h expected 0", all_out);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
      #1;
      checks++;
      if (pc_stall !== 1'b0) begin
         errors++; $display("FAIL lu_c0_stall: got %b expected 0", pc_stall);
      end
      step();
      set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x7
      #1;
      checks++;
      if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1110) begin
         errors++; $display("FAIL lu_c1_ctrl: got %b expected 1110",
                            {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
      end
      step();
      #1;
      checks++;
      if ({pc_stall, id_ex_bubble} !== 2'b00) begin
         errors++; $display("FAIL lu_c2_single_bubble: got %b expected 00", {pc_stall, id_ex_bubble});
      end
      checks++;
      if ({EX_MEM_RegWrite, EX_MEM_rd} !== {1'b1, 5'd5}) begin
         errors++; $display("FAIL lu_c2_exmem: got %b/%0d expected 1/5", EX_MEM_RegWrite, EX_MEM_rd);
      end
      checks++;
      if (ID_EX_rs1 !== 5'd0) begin
         errors++; $display("FAIL lu_c2_bubble_idex: got %0d expected 0", ID_EX_rs1);
      end
      step();
      set_nop();
      #1;
      checks++;
      if ({MEM_WB_RegWrite, MEM_WB_rd} !== {1'b1, 5'd5}) begin
         errors++; $display("FAIL lu_c3_memwb: got %b/%0d expected 1/5", MEM_WB_RegWrite, MEM_WB_rd);
      end
      checks++;
      if ({ID_EX_rs1, ID_EX_rs2, EX_MEM_rd} !== {5'd5, 5'd7, 5'd0}) begin
         errors++; $display("FAIL lu_c3_advance: got %0d/%0d/%0d expected 5/7/0",
                            ID_EX_rs1, ID_EX_rs2, EX_MEM_rd);
      end
      checks++;
      if (stall_count !== 16'd1) begin
         errors++; $display("FAIL lu_stall_count: got %0d expected 1", stall_count);
      end
   endtask

   task automatic test_no_false_stall();
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
      step();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x0,x0
      #1;
      checks++;
      if ({pc_stall, id_ex_bubble} !== 2'b00) begin
         errors++; $display("FAIL nfs_x0: got %b expected 00", {pc_stall, id_ex_bubble});
      end
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
      step();
      set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // rs2=5 unused
      #1;
      checks++;
      if ({pc_stall, id_ex_bubble} !== 2'b00) begin
         errors++; $display("FAIL nfs_rs2_unused: got %b expected 00", {pc_stall, id_ex_bubble});
      end
      step();
      set_nop();
      #1;
      checks++;
      if (stall_count !== 16'd0) begin
         errors++; $display("FAIL nfs_stall_count: got %0d expected 0", stall_count);
      end
   endtask

   task automatic test_branch_luse();
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
      step();
      set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      branch_taken_ex = 1'b1;
      #1;
      checks++;
      if ({if_id_flush, id_ex_bubble} !== 2'b11) begin
         errors++; $display("FAIL br_flush: got %b expected 11", {if_id_flush, id_ex_bubble});
      end
      checks++;
      if ({pc_stall, if_id_stall} !== 2'b00) begin
         errors++; $display("FAIL br_no_stall: got %b expected 00", {pc_stall, if_id_stall});
      end
      step();
      branch_taken_ex = 1'b0;
      set_nop();
      #1;
      checks++;
      if ({ID_EX_rs1, ID_EX_rs2} !== 10'd0) begin
         errors++; $display("FAIL br_idex_nop: got %0d/%0d expected 0/0", ID_EX_rs1, ID_EX_rs2);
      end
      checks++;
      if ({EX_MEM_RegWrite, EX_MEM_rd} !== {1'b1, 5'd5}) begin
         errors++; $display("FAIL br_exmem_load: got %b/%0d expected 1/5", EX_MEM_RegWrite, EX_MEM_rd);
      end
      step();
      #1;
      checks++;
      if ({EX_MEM_RegWrite, EX_MEM_rd} !== 6'd0) begin
         errors++; $display("FAIL br_nop_regwrite: got %b/%0d expected 0/0", EX_MEM_RegWrite, EX_MEM_rd);
      end
      checks++;
      if (stall_count !== 16'd0) begin
         errors++; $display("FAIL br_stall_count: got %0d expected 0", stall_count);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
      step();
      set_id(1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // sw
      step();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // add x7
      step();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // addi x8
      mem_ready = 1'b0;
      #1;
      checks++;
      if ({pipe_freeze, pc_stall, if_id_stall} !== 3'b111) begin
         errors++; $display("FAIL mw_freeze_c0: got %b expected 111", {pipe_freeze, pc_stall, if_id_stall});
      end
      step();
      branch_taken_ex = 1'b1;
      #1;
      checks++;
      if ({pipe_freeze, if_id_flush, id_ex_bubble} !== 3'b100) begin
         errors++; $display("FAIL mw_branch_ignored: got %b expected 100",
                            {pipe_freeze, if_id_flush, id_ex_bubble});
      end
      checks++;
      if ({EX_MEM_rd, MEM_WB_rd} !== {5'd0, 5'd3}) begin
         errors++; $display("FAIL mw_hold_c1: got %0d/%0d expected 0/3", EX_MEM_rd, MEM_WB_rd);
      end
      step();
      branch_taken_ex = 1'b0;
      #1;
      checks++;
      if ({pipe_freeze, EX_MEM_rd, MEM_WB_rd} !== {1'b1, 5'd0, 5'd3}) begin
         errors++; $display("FAIL mw_hold_c2: got %b/%0d/%0d expected 1/0/3",
                            pipe_freeze, EX_MEM_rd, MEM_WB_rd);
      end
      step();
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({pipe_freeze, pc_stall} !== 2'b00) begin
         errors++; $display("FAIL mw_release: got %b expected 00", {pipe_freeze, pc_stall});
      end
      step();
      set_nop();
      #1;
      checks++;
      if ({EX_MEM_RegWrite, EX_MEM_rd, MEM_WB_RegWrite, MEM_WB_rd} !== {1'b1, 5'd7, 1'b0, 5'd0}) begin
         errors++; $display("FAIL mw_advance: got %b/%0d/%b/%0d expected 1/7/0/0",
                            EX_MEM_RegWrite, EX_MEM_rd, MEM_WB_RegWrite, MEM_WB_rd);
      end
      checks++;
      if (stall_count !== 16'd3) begin
         errors++; $display("FAIL mw_stall_count: got %0d expected 3", stall_count);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);   // lw x4
      step();
      set_nop();
      step();
      mem_ready = 1'b0;
      #1;
      checks++;
      if (pipe_freeze !== 1'b1) begin
         errors++; $display("FAIL to_freeze_start: got %b expected 1", pipe_freeze);
      end
      step();
      step();
      step();
      #1;
      checks++;
      if ({pipe_freeze, mem_timeout} !== 2'b10) begin
         errors++; $display("FAIL to_before_limit: got %b expected 10", {pipe_freeze, mem_timeout});
      end
      step();
      #1;
      checks++;
      if ({pipe_freeze, mem_timeout} !== 2'b11) begin
         errors++; $display("FAIL to_asserted: got %b expected 11", {pipe_freeze, mem_timeout});
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (pipe_freeze !== 1'b1) begin
         errors++; $display("FAIL to_ready_still_frozen: got %b expected 1", pipe_freeze);
      end
      step();
      checks++;
      if ({pipe_freeze, mem_timeout, stall_count} !== {2'b11, 16'd5}) begin
         errors++; $display("FAIL to_sticky: got %b/%b/%0d expected 1/1/5",
                            pipe_freeze, mem_timeout, stall_count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== 44'd0) begin
         errors++; $display("FAIL to_reset_clears: got %h expected 0", all_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      step();
      checks++;
      if ({pipe_freeze, mem_timeout} !== 2'b00) begin
         errors++; $display("FAIL to_back_to_run: got %b expected 00", {pipe_freeze, mem_timeout});
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);   // add x1
      step();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);   // add x2
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw x3
      step();
      set_id(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);   // uses x3
      #1;
      checks++;
      if ({pc_stall, EX_MEM_rd, MEM_WB_rd} !== {1'b1, 5'd2, 5'd1}) begin
         errors++; $display("FAIL ar_filled: got %b/%0d/%0d expected 1/2/1", pc_stall, EX_MEM_rd, MEM_WB_rd);
      end
      step();
      checks++;
      if ({EX_MEM_rd, MEM_WB_rd, ID_EX_rs1, stall_count} !== {5'd3, 5'd2, 5'd0, 16'd1}) begin
         errors++; $display("FAIL ar_before_rst: got %0d/%0d/%0d/%0d expected 3/2/0/1",
                            EX_MEM_rd, MEM_WB_rd, ID_EX_rs1, stall_count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== 44'd0) begin
         errors++; $display("FAIL ar_async_clear: got %h expected 0", all_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_nop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      set_nop();
      branch_taken_ex = 1'b0;
      mem_ready = 1'b1;
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_branch_luse();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
